spi_controller: RTL and testbench

SPI mode-0 controller (initiator) that drives the 16-bit register-access frame consumed by the chip's SPI register-file peripheral.
- Frame format: {rw, addr[6:0], data[7:0]}, MSB first.
- Accepts one request at a time from an on-chip client through a valid/ready handshake.
- Generates SCLK, nCS and COPI from clk.
- Samples CIPO during the data byte of reads and returns one response per frame.
- Used as the bench/system-side driver for the register file and for chip-to-chip register access.

---
 rtl/spi_controller.sv | 129 ++++++++++++
 tb/tb_spi_controller.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// SPI mode-0 initiator for the 16-bit {rw, addr[6:0], data[7:0]} register-access frame.
// One request at a time over valid/ready; one response pulse per completed frame.
module spi_controller #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned IDLE_GAP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       SCLK,
  output logic       COPI,
  output logic       nCS,
  input  logic       CIPO
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     lim_c;
  logic                 done_c;
  logic [IDX_W-1:0]     bit_idx;
  logic [FRAME_W-1:0]   frame;
  logic [7:0]           shreg;

  // Terminal count of the phase timer for the current state.
  always_comb begin
    lim_c = '0;
    unique case (state)
      SETUP:     lim_c = CNT_W'(CS_SETUP - 1);
      LOW, HIGH: lim_c = CNT_W'(CLK_DIV - 1);
      HOLD:      lim_c = CNT_W'(CS_HOLD - 1);
      GAP:       lim_c = CNT_W'(IDLE_GAP - 1);
      default:   lim_c = '0;
    endcase
  end

  assign done_c = (cnt == lim_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      frame     <= '0;
      shreg     <= '0;
      SCLK      <= 1'b0;
      COPI      <= 1'b0;
      nCS       <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      if (state != IDLE) begin
        cnt <= done_c ? '0 : cnt + CNT_W'(1);
      end
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            frame     <= {req_rw, req_addr, req_rw ? req_wdata : 8'h00};
            nCS       <= 1'b0;
            COPI      <= req_rw;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            bit_idx   <= IDX_W'(15);
            cnt       <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (done_c) state <= LOW;
        end
        LOW: begin
          if (done_c) begin
            SCLK <= 1'b1;
            // Data byte is sampled on the rising edge with the value CIPO holds now.
            if (bit_idx <= IDX_W'(7)) shreg <= {shreg[6:0], CIPO};
            state <= HIGH;
          end
        end
        HIGH: begin
          if (done_c) begin
            SCLK <= 1'b0;
            if (bit_idx == '0) begin
              state <= HOLD;
            end else begin
              bit_idx <= bit_idx - IDX_W'(1);
              COPI    <= frame[bit_idx - IDX_W'(1)];
              state   <= LOW;
            end
          end
        end
        HOLD: begin
          if (done_c) begin
            nCS       <= 1'b1;
            COPI      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= frame[15] ? 8'h00 : shreg;
            state     <= GAP;
          end
        end
        GAP: begin
          if (done_c) begin
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: default instance plus a CLK_DIV=1 instance,
// each with a register-file peripheral model and a frame/response monitor.
module tb_spi_controller;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid, req_rw, req_ready, rsp_valid, busy, sclk, copi, ncs;
  logic [6:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic [7:0] rsp_rdata [2];

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_frame [$];
  logic [7:0]  exp_rsp   [$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endfunction

  function automatic void fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned DIV     = (g == 0) ? 4 : 1;
    localparam int unsigned SU      = (g == 0) ? 2 : 1;
    localparam int unsigned HO      = (g == 0) ? 2 : 1;
    localparam int unsigned NCS_LOW = (g == 0) ? 132 : 34;
    localparam int unsigned SPAN    = (g == 0) ? 120 : 30;

    logic        cipo;
    logic [7:0]  mem [128];
    logic [15:0] sh, cap;
    logic [7:0]  rd;
    bit          init_done = 0;
    int          pcnt = 0, nrise = 0, low_cyc = 0, first_r = 0, last_r = 0;
    int          gap = 0, last_gap = 0, frames = 0, rsps = 0;
    logic        ncs_q = 1'b1, sclk_q = 1'b0, rsp_q = 1'b0;
    bit          in_frame = 0, had_frame = 0, bad_hs = 0;

    spi_controller #(.CLK_DIV(DIV), .CS_SETUP(SU), .CS_HOLD(HO), .IDLE_GAP(2)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_rw    (req_rw[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .busy      (busy[g]),
      .SCLK      (sclk[g]),
      .COPI      (copi[g]),
      .nCS       (ncs[g]),
      .CIPO      (cipo)
    );

    always @(negedge clk) begin
      if (!init_done) begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[4]    = 8'h3C;
        mem[17]   = 8'hC3;
        cipo      = 1'b0;
        sh        = '0;
        rd        = '0;
        init_done = 1;
      end

      // Peripheral: capture on SCLK rise, drive read byte after each SCLK fall.
      if (!ncs[g] && ncs_q) pcnt = 0;
      if (ncs[g]) begin
        cipo = 1'b0;
      end else if (sclk[g] && !sclk_q) begin
        sh = {sh[14:0], copi[g]};
        pcnt++;
        if (pcnt == 8) rd = mem[sh[6:0]];
        if (pcnt == 16 && sh[15]) mem[sh[14:8]] = sh[7:0];
      end else if (!sclk[g] && sclk_q && pcnt >= 8 && pcnt < 16) begin
        cipo = rd[3'(15 - pcnt)];
      end

      if (!rst_n) begin
        in_frame = 0;
        bad_hs   = 0;
      end else begin
        if (!ncs[g] && ncs_q) begin
          if (had_frame) chk("ncs_high_gap_ge2", 32'(gap >= 2), 32'd1);
          last_gap = gap;
          in_frame = 1;
          low_cyc  = 0;
          nrise    = 0;
          cap      = '0;
          bad_hs   = 0;
        end
        if (!ncs[g] && in_frame) begin
          low_cyc++;
          if (req_ready[g] || !busy[g]) bad_hs = 1;
          if (sclk[g] && !sclk_q) begin
            cap = {cap[14:0], copi[g]};
            if (nrise == 0) first_r = low_cyc;
            last_r = low_cyc;
            nrise++;
          end
        end
        if (ncs[g] && !ncs_q && in_frame) begin
          if (exp_frame.size() == 0) fail("frame_unexpected");
          else chk("frame_bits", 32'(cap), 32'(exp_frame.pop_front()));
          chk("sclk_rises", 32'(nrise), 32'd16);
          chk("ncs_low_cycles", 32'(low_cyc), NCS_LOW);
          chk("sclk_rise_span", 32'(last_r - first_r), SPAN);
          chk("ready_low_busy_high_in_frame", 32'(bad_hs), 32'd0);
          in_frame  = 0;
          had_frame = 1;
          gap       = 0;
          frames++;
        end
        if (ncs[g]) gap++;
        if (rsp_valid[g]) begin
          rsps++;
          chk("rsp_single_cycle", 32'(rsp_q), 32'd0);
          chk("rsp_with_ncs_rise", 32'(ncs[g] && !ncs_q), 32'd1);
          if (exp_rsp.size() == 0) fail("rsp_unexpected");
          else chk("rsp_rdata", 32'(rsp_rdata[g]), 32'(exp_rsp.pop_front()));
        end
      end
      ncs_q  = ncs[g];
      sclk_q = sclk[g];
      rsp_q  = rsp_valid[g];
    end
  end

  task automatic send(input int sel, input logic rw, input logic [6:0] a, input logic [7:0] d,
                      input logic [15:0] ef, input logic [7:0] er, input bit track);
    bit ok = 0;
    req_valid[sel] = 1'b1;
    req_rw[sel]    = rw;
    req_addr[sel]  = a;
    req_wdata[sel] = d;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (req_ready[sel]) begin
        @(posedge clk);
        if (track) begin
          exp_frame.push_back(ef);
          exp_rsp.push_back(er);
        end
        ok = 1;
      end
      @(negedge clk);
    end
    if (!ok) fail("send_timeout");
  endtask

  task automatic wait_idle(input int sel);
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (!busy[sel] && req_ready[sel] && ncs[sel]) ok = 1;
    end
    if (!ok) fail("idle_timeout");
  endtask

  initial begin
    bit ok;
    bit bad;
    int rsp_before;
    rst_n     = 1'b0;
    req_valid = '0;
    req_rw    = '0;
    for (int i = 0; i < 2; i++) begin
      req_addr[i]  = '0;
      req_wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ncs", 32'(ncs[i]), 32'd1);
      chk("rst_sclk", 32'(sclk[i]), 32'd0);
      chk("rst_copi", 32'(copi[i]), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      chk("rst_rsp_rdata", 32'(rsp_rdata[i]), 32'h00);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_req_ready", 32'(req_ready[i]), 32'd1);
    end
    rst_n = 1'b1;

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (sclk != 2'b00 || ncs != 2'b11 || copi != 2'b00 || rsp_valid != 2'b00) bad = 1;
    end
    chk("idle_quiet_1000", 32'(bad), 32'd0);

    send(0, 1'b1, 7'h02, 8'hA5, 16'h82A5, 8'h00, 1);
    req_valid[0] = 1'b0;
    wait_idle(0);
    chk("periph_reg2", 32'(g_inst[0].mem[2]), 32'hA5);

    send(0, 1'b0, 7'h04, 8'hEE, 16'h0400, 8'h3C, 1);
    req_valid[0] = 1'b0;
    wait_idle(0);
    repeat (5) @(negedge clk);
    chk("rdata_hold", 32'(rsp_rdata[0]), 32'h3C);

    send(0, 1'b0, 7'h02, 8'h00, 16'h0200, 8'hA5, 1);
    req_valid[0] = 1'b0;
    wait_idle(0);

    // Back-to-back with req_valid held high across both accepts.
    send(0, 1'b1, 7'h00, 8'hFF, 16'h80FF, 8'h00, 1);
    send(0, 1'b1, 7'h01, 8'h0F, 16'h810F, 8'h00, 1);
    req_valid[0] = 1'b0;
    wait_idle(0);
    chk("b2b_ncs_gap", 32'(g_inst[0].last_gap), 32'd3);

    send(0, 1'b1, 7'h05, 8'h12, 16'h8512, 8'h00, 1);
    req_valid[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_addr[0]  = 7'h7F;
      req_wdata[0] = 8'h00;
      @(negedge clk);
      req_valid[0] = 1'b0;
    end
    wait_idle(0);
    repeat (10) @(negedge clk);

    // Abort a write mid-frame with reset.
    rsp_before = g_inst[0].rsps;
    send(0, 1'b1, 7'h03, 8'h99, 16'h0000, 8'h00, 0);
    req_valid[0] = 1'b0;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      if (g_inst[0].pcnt == 5) ok = 1;
    end
    if (!ok) fail("fifth_rise_timeout");
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ncs", 32'(ncs[0]), 32'd1);
    chk("abort_sclk", 32'(sclk[0]), 32'd0);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_req_ready", 32'(req_ready[0]), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("abort_no_rsp", 32'(g_inst[0].rsps), 32'(rsp_before));

    send(0, 1'b1, 7'h03, 8'h55, 16'h8355, 8'h00, 1);
    req_valid[0] = 1'b0;
    wait_idle(0);
    send(0, 1'b0, 7'h03, 8'h00, 16'h0300, 8'h55, 1);
    req_valid[0] = 1'b0;
    wait_idle(0);

    send(1, 1'b0, 7'h11, 8'h00, 16'h1100, 8'hC3, 1);
    req_valid[1] = 1'b0;
    wait_idle(1);
    send(1, 1'b1, 7'h22, 8'h5A, 16'hA25A, 8'h00, 1);
    req_valid[1] = 1'b0;
    wait_idle(1);
    chk("dut1_periph_reg22", 32'(g_inst[1].mem[34]), 32'h5A);

    repeat (10) @(negedge clk);
    chk("frames_dut0", 32'(g_inst[0].frames), 32'd8);
    chk("frames_dut1", 32'(g_inst[1].frames), 32'd2);
    chk("frame_queue_drained", 32'(exp_frame.size()), 32'd0);
    chk("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

endmodule
